// File: rtl/sram_responder.sv
// Clocked stand-in for a 16-bit asynchronous SRAM: pins are registered on clk, reads are served
// after a programmable latency, writes commit when the write pulse ends, and violations are flagged.
module sram_responder #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int MEM_WORDS  = 4096,
  parameter int READ_LAT   = 3,
  parameter int MIN_WE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_dq,
  input  logic              sram_ce_n,
  input  logic              sram_oe_n,
  input  logic              sram_we_n,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              err_we_short,
  output logic              err_addr_wr,
  output logic              err_oe_we
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] dq_q;
  logic [DATA_W-1:0] wr_data;
  logic              ce_q;
  logic              oe_q;
  logic              we_q;
  logic [7:0]        cnt;
  logic [7:0]        pulse;
  logic              wr_active;
  logic              rd_req;
  logic              mem_we;

  // Contents start at zero and deliberately survive rst, like the real part across a controller reset.
  logic [DATA_W-1:0] mem [MEM_WORDS] = '{default: '0};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Input stage: the FSM only ever looks at these registered copies of the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_q <= 1'b1;
      oe_q <= 1'b1;
      we_q <= 1'b1;
    end else begin
      ce_q <= sram_ce_n;
      oe_q <= sram_oe_n;
      we_q <= sram_we_n;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= sram_addr;
    dq_q   <= sram_dq;
  end

  assign wr_active = !ce_q && !we_q;
  assign rd_req    = !ce_q && !oe_q;
  assign mem_we    = (state == WRITE) && !wr_active && (pulse >= 8'(MIN_WE_CYC));

  // Protocol FSM stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pulse        <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      err_we_short <= 1'b0;
      err_addr_wr  <= 1'b0;
      err_oe_we    <= 1'b0;
    end else begin
      if (rd_req && !we_q) err_oe_we <= 1'b1;
      case (state)
        IDLE, READ_WAIT, READ_DRIVE: begin
          if (wr_active) begin
            state   <= WRITE;
            wr_addr <= addr_q;
            wr_data <= dq_q;
            pulse   <= 8'd1;
          end else if (!rd_req) begin
            state <= IDLE;
          end else if (state == IDLE || addr_q != rd_addr) begin
            state   <= READ_WAIT;
            rd_addr <= addr_q;
            cnt     <= 8'd1;
          end else if (state == READ_WAIT) begin
            if (cnt == 8'(READ_LAT)) begin
              state    <= READ_DRIVE;
              rd_count <= rd_count + 16'd1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        WRITE: begin
          if (wr_active) begin
            pulse   <= sat_inc8(pulse);
            wr_data <= dq_q;
            if (addr_q != wr_addr) err_addr_wr <= 1'b1;
          end else begin
            if (pulse >= 8'(MIN_WE_CYC)) wr_count <= wr_count + 16'd1;
            else                         err_we_short <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write stage: commit happens on the edge that sees the pulse end.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  assign sram_dq = (state == READ_DRIVE) ? mem[rd_addr[IDX_W-1:0]] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: table of write/read transactions plus hand-built corner sequences.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] rd_count;
  logic [15:0] wr_count;
  logic        err_we_short;
  logic        err_addr_wr;
  logic        err_oe_we;
  logic [15:0] dq_drv;
  logic        dq_en;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_q[$];

  assign sram_dq = dq_en ? dq_drv : 16'hzzzz;

  sram_responder dut (
    .clk(clk), .rst(rst), .sram_addr(sram_addr), .sram_dq(sram_dq),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .rd_count(rd_count), .wr_count(wr_count), .err_we_short(err_we_short),
    .err_addr_wr(err_addr_wr), .err_oe_we(err_oe_we)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        is_wr;
    logic [16:0] addr;
    logic [15:0] data;
    int          we_cyc;
    logic [15:0] exp_wr;
    logic [15:0] exp_rd;
    logic [2:0]  exp_err;  // {oe_we, addr_wr, we_short}
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pins_idle();
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    dq_en     = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [15:0] ewr, input logic [15:0] erd,
                              input logic [2:0] eerr);
    check({tag, "_wr_count"}, 32'(wr_count), 32'(ewr));
    check({tag, "_rd_count"}, 32'(rd_count), 32'(erd));
    check({tag, "_errs"}, 32'({err_oe_we, err_addr_wr, err_we_short}), 32'(eerr));
  endtask

  task automatic do_write(input logic [16:0] a, input logic [15:0] d, input int n);
    sram_addr = a;
    dq_drv    = d;
    dq_en     = 1'b1;
    sram_oe_n = 1'b1;
    sram_ce_n = 1'b0;
    sram_we_n = 1'b0;
    repeat (n) cyc();
    sram_we_n = 1'b1;
    sram_ce_n = 1'b1;
    cyc();
    dq_en = 1'b0;
    repeat (2) cyc();
  endtask

  // Starts a read and leaves it driving; data must appear READ_LAT+1 edges after the sampling edge.
  task automatic start_read(input logic [16:0] a, input logic [15:0] exp);
    int n;
    logic [15:0] e;
    sram_addr = a;
    dq_en     = 1'b0;
    sram_we_n = 1'b1;
    sram_ce_n = 1'b0;
    sram_oe_n = 1'b0;
    exp_q.push_back(exp);
    n = 0;
    if (exp != 16'h0000) begin
      while (n < 12 && sram_dq !== exp) begin
        cyc();
        n++;
      end
      check("rd_latency", 32'(n), 32'd5);
    end else begin
      repeat (5) cyc();
    end
    e = exp_q.pop_front();
    check("rd_data", 32'(sram_dq), 32'(e));
  endtask

  task automatic end_read(input logic [15:0] exp);
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    cyc();
    check("bus_hold", 32'(sram_dq), 32'(exp));
    cyc();
    if (exp != 16'h0000) check("bus_release", 32'(sram_dq === exp), 32'd0);
    cyc();
  endtask

  initial begin
    vecs[0] = '{1'b1, 17'h00010, 16'hA5A5, 3, 16'd1, 16'd0, 3'b000};
    vecs[1] = '{1'b0, 17'h00010, 16'hA5A5, 0, 16'd1, 16'd1, 3'b000};
    vecs[2] = '{1'b0, 17'h00020, 16'h0000, 0, 16'd1, 16'd2, 3'b000};
    vecs[3] = '{1'b1, 17'h00030, 16'h1234, 1, 16'd1, 16'd2, 3'b001};
    vecs[4] = '{1'b0, 17'h00030, 16'h0000, 0, 16'd1, 16'd3, 3'b001};
    vecs[5] = '{1'b1, 17'h00050, 16'hC3C3, 2, 16'd2, 16'd3, 3'b001};
    vecs[6] = '{1'b0, 17'h00050, 16'hC3C3, 0, 16'd2, 16'd4, 3'b001};
    vecs[7] = '{1'b0, 17'h01010, 16'hA5A5, 0, 16'd2, 16'd5, 3'b001};

    rst       = 1'b1;
    sram_addr = '0;
    dq_drv    = '0;
    pins_idle();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    check_status("reset", 16'd0, 16'd0, 3'b000);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].we_cyc);
      end else begin
        start_read(vecs[i].addr, vecs[i].data);
        end_read(vecs[i].data);
      end
      check_status($sformatf("vec%0d", i), vecs[i].exp_wr, vecs[i].exp_rd, vecs[i].exp_err);
    end

    // Address change while data is on the bus: release, then new data 3 cycles after release.
    start_read(17'h00020, 16'h0000);
    check("addr_chg_rd_count0", 32'(rd_count), 32'd6);
    sram_addr = 17'h00010;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("addr_chg_not_yet%0d", k), 32'(sram_dq === 16'hA5A5), 32'd0);
    end
    cyc();
    check("addr_chg_new_data", 32'(sram_dq), 32'h0000A5A5);
    end_read(16'hA5A5);
    check("addr_chg_rd_count1", 32'(rd_count), 32'd7);

    // Address moves 0x40 -> 0x41 while WE# is low; data lands at 0x40.
    sram_addr = 17'h00040;
    dq_drv    = 16'hBEEF;
    dq_en     = 1'b1;
    sram_ce_n = 1'b0;
    sram_we_n = 1'b0;
    repeat (2) cyc();
    sram_addr = 17'h00041;
    repeat (2) cyc();
    sram_we_n = 1'b1;
    sram_ce_n = 1'b1;
    cyc();
    dq_en = 1'b0;
    repeat (2) cyc();
    check_status("addr_wr", 16'd3, 16'd7, 3'b011);
    start_read(17'h00040, 16'hBEEF);
    end_read(16'hBEEF);
    start_read(17'h00041, 16'h0000);
    end_read(16'h0000);
    check("addr_wr_rd_count", 32'(rd_count), 32'd9);

    // CE#, OE#, WE# all low over a word holding known data: bus must never show it.
    do_write(17'h00060, 16'h6666, 3);
    sram_addr = 17'h00060;
    sram_ce_n = 1'b0;
    sram_oe_n = 1'b0;
    sram_we_n = 1'b0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      check($sformatf("oe_we_no_drive%0d", k), 32'(sram_dq === 16'h6666), 32'd0);
    end
    pins_idle();
    repeat (3) cyc();
    check("oe_we_flag", 32'(err_oe_we), 32'd1);

    // Asynchronous reset clears status without a clock edge.
    rst = 1'b1;
    #1;
    check_status("async_rst", 16'd0, 16'd0, 3'b000);
    cyc();
    rst = 1'b0;
    cyc();

    // Reset in the middle of a write discards it.
    sram_addr = 17'h00070;
    dq_drv    = 16'h7777;
    dq_en     = 1'b1;
    sram_ce_n = 1'b0;
    sram_we_n = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    #1;
    pins_idle();
    repeat (2) cyc();
    rst = 1'b0;
    repeat (3) cyc();
    check_status("mid_wr_rst", 16'd0, 16'd0, 3'b000);

    start_read(17'h00010, 16'hA5A5);
    end_read(16'hA5A5);
    start_read(17'h00070, 16'h0000);
    end_read(16'h0000);
    check_status("post_rst", 16'd0, 16'd2, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
